hist_pingpong: RTL

- Parametrised successor to the single-bank luma histogram in the video filter top.
- Double-buffered: one bank accumulates the current frame while the other holds the last completed frame for the AXI-side readout.
- Configurable pixel width, bin count and counter width; clears the accumulating bank in hardware; forwards read-modify-write results for same-bin pixel runs.
- Sits after the rgb2y stage on the gray pixel stream, in parallel with the blur/sobel chain.

---
 rtl/hist_pingpong.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/hist_pingpong.sv
// hist_pingpong: double-buffered gray-level histogram with hardware bank clear and RMW forwarding.
// Optional macro HIST_SAT_EN: bin counters saturate at all-ones instead of wrapping.
module hist_pingpong #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned BIN_BITS = 8,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned POL_VS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PIX_W-1:0]    pix_i,
  input  logic                dv_i,
  input  logic                vs_i,
  input  logic [BIN_BITS-1:0] rd_addr_i,
  input  logic                rd_req_i,
  output logic                rd_ack_o,
  output logic [CNT_W-1:0]    rd_data_o,
  output logic [15:0]         rd_frame_o,
  output logic [15:0]         frame_cnt_o,
  output logic                valid_o,
  output logic                ovr_o
);

  localparam int unsigned NBINS = 1 << BIN_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    CLEAR   = 2'd1,
    ACCUM   = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                vs_act_c, vs_act_q, vs_rise_c;
  logic [BIN_BITS-1:0] clr_addr_q;
  logic                drain_q;
  logic                bank_sel_q;

  logic                pix_take_c, ovr_set_c, swap_c;

  logic                s0_vld_q, s1_vld_q, s2_vld_q;
  logic [BIN_BITS-1:0] s0_bin_q, s1_bin_q, s2_bin_q;
  logic [CNT_W-1:0]    s2_cnt_q;
  logic [CNT_W-1:0]    cur_c, inc_c, acc_rd_c;

  logic                wr_en_c;
  logic [BIN_BITS-1:0] wr_addr_c;
  logic [CNT_W-1:0]    wr_data_c;

  logic [CNT_W-1:0]    mem0 [NBINS];
  logic [CNT_W-1:0]    mem1 [NBINS];
  logic [CNT_W-1:0]    acc_rd0_q, acc_rd1_q, out_rd0_q, out_rd1_q;

  logic                req_q1, req_q2, req_q3, rd_edge_c;
  logic                rd_p1_q, rd_bank_q;
  logic [15:0]         rd_frm_q;

  assign vs_act_c  = (POL_VS != 0) ? vs_i : ~vs_i;
  assign vs_rise_c = vs_act_c & ~vs_act_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_VS;
    else     state_q <= state_d;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_d    = state_q;
    pix_take_c = 1'b0;
    ovr_set_c  = 1'b0;
    swap_c     = 1'b0;
    case (state_q)
      WAIT_VS: begin
        ovr_set_c = dv_i;
        if (vs_rise_c) state_d = CLEAR;
      end
      CLEAR: begin
        ovr_set_c = dv_i;
        if (&clr_addr_q) state_d = ACCUM;
      end
      ACCUM: begin
        pix_take_c = dv_i;
        if (vs_rise_c) state_d = DRAIN;
      end
      DRAIN: begin
        ovr_set_c = dv_i;
        if (drain_q) begin
          swap_c  = 1'b1;
          state_d = CLEAR;
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  // Frame bookkeeping: clear sweep, drain timer, bank swap, status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_act_q    <= 1'b0;
      clr_addr_q  <= '0;
      drain_q     <= 1'b0;
      bank_sel_q  <= 1'b0;
      frame_cnt_o <= '0;
      valid_o     <= 1'b0;
      ovr_o       <= 1'b0;
    end else begin
      vs_act_q <= vs_act_c;
      if (state_q == CLEAR) clr_addr_q <= clr_addr_q + BIN_BITS'(1);
      else                  clr_addr_q <= '0;
      if (state_q == DRAIN) drain_q <= ~drain_q;
      else                  drain_q <= 1'b0;
      if (swap_c) begin
        bank_sel_q  <= ~bank_sel_q;
        frame_cnt_o <= frame_cnt_o + 16'd1;
        valid_o     <= 1'b1;
      end
      if (ovr_set_c) ovr_o <= 1'b1;
    end
  end

  // S1 count: forward the previous write when it hit the same bin
  assign acc_rd_c = bank_sel_q ? acc_rd1_q : acc_rd0_q;
  assign cur_c    = (s2_vld_q && (s2_bin_q == s1_bin_q)) ? s2_cnt_q : acc_rd_c;

`ifdef HIST_SAT_EN
  assign inc_c = (cur_c == CNT_MAX) ? cur_c : cur_c + CNT_W'(1);
`else
  assign inc_c = cur_c + CNT_W'(1);
`endif

  // Increment pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld_q <= 1'b0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s0_bin_q <= '0;
      s1_bin_q <= '0;
      s2_bin_q <= '0;
      s2_cnt_q <= '0;
    end else begin
      s0_vld_q <= pix_take_c;
      s0_bin_q <= pix_i[PIX_W-1 -: BIN_BITS];
      s1_vld_q <= s0_vld_q;
      s1_bin_q <= s0_bin_q;
      s2_vld_q <= s1_vld_q;
      s2_bin_q <= s1_bin_q;
      s2_cnt_q <= inc_c;
    end
  end

  // Single write port into the accumulating bank: clear sweep or S1 result
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = s1_bin_q;
    wr_data_c = inc_c;
    if (state_q == CLEAR) begin
      wr_en_c   = 1'b1;
      wr_addr_c = clr_addr_q;
      wr_data_c = '0;
    end else if (s1_vld_q) begin
      wr_en_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c && !bank_sel_q) mem0[wr_addr_c] <= wr_data_c;
    acc_rd0_q <= mem0[s0_bin_q];
    out_rd0_q <= mem0[rd_addr_i];
  end

  always_ff @(posedge clk) begin
    if (wr_en_c && bank_sel_q) mem1[wr_addr_c] <= wr_data_c;
    acc_rd1_q <= mem1[s0_bin_q];
    out_rd1_q <= mem1[rd_addr_i];
  end

  assign rd_edge_c = req_q2 & ~req_q3;

  // Readout: synchronise request, read readable bank, then present and toggle ack
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q1     <= 1'b0;
      req_q2     <= 1'b0;
      req_q3     <= 1'b0;
      rd_p1_q    <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_frm_q   <= '0;
      rd_ack_o   <= 1'b0;
      rd_data_o  <= '0;
      rd_frame_o <= '0;
    end else begin
      req_q1  <= rd_req_i;
      req_q2  <= req_q1;
      req_q3  <= req_q2;
      rd_p1_q <= rd_edge_c;
      if (rd_edge_c) begin
        rd_bank_q <= ~bank_sel_q;
        rd_frm_q  <= frame_cnt_o;
      end
      if (rd_p1_q) begin
        rd_data_o  <= rd_bank_q ? out_rd1_q : out_rd0_q;
        rd_frame_o <= rd_frm_q;
        rd_ack_o   <= ~rd_ack_o;
      end
    end
  end

endmodule
